// File: rtl/branch_predictor_pht.sv
// Direct-mapped BTB with per-entry 2-bit direction counters, a circular return-address
// stack and saturating update/mispredict statistics. Lookup is combinational, updates are synchronous.
module branch_predictor_pht #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 8,
  parameter int MODE       = 1,
  parameter int RAS_DEPTH  = 4,
  parameter int STAT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 predict_taken,
  output logic [WORD_SIZE-1:0] predict_target,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_is_jump,
  input  logic                 upd_mispredict,
  input  logic                 clear,
  input  logic                 ras_push,
  input  logic [WORD_SIZE-1:0] ras_push_addr,
  input  logic                 ras_pop,
  output logic [WORD_SIZE-1:0] ras_top,
  output logic                 ras_empty,
  output logic [STAT_W-1:0]    stat_updates,
  output logic [STAT_W-1:0]    stat_mispredicts
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_mem [DEPTH];
  logic [WORD_SIZE-1:0] tgt_mem [DEPTH];
  logic [1:0]           ctr_mem [DEPTH];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit, up_hit;
  logic [1:0]            cur_ctr, ctr_nxt;
  logic                  wr_alloc, wr_tgt, wr_ctr, inval;
  logic                  accept;

  assign lk_idx = lookup_pc[INDEX_BITS-1:0];
  assign lk_tag = lookup_pc[INDEX_BITS +: TAG_BITS];
  assign up_idx = upd_pc[INDEX_BITS-1:0];
  assign up_tag = upd_pc[INDEX_BITS +: TAG_BITS];
  assign accept = upd_valid & ~clear;

  assign lk_hit         = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign predict_taken  = (MODE == 0) ? lk_hit : (lk_hit & ctr_mem[lk_idx][1]);
  assign predict_target = tgt_mem[lk_idx];

  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
    cur_ctr  = ctr_mem[up_idx];
    ctr_nxt  = cur_ctr;
    wr_alloc = 1'b0;
    wr_tgt   = 1'b0;
    wr_ctr   = 1'b0;
    inval    = 1'b0;
    if (upd_is_jump) begin
      wr_alloc = 1'b1;
      wr_tgt   = 1'b1;
      wr_ctr   = 1'b1;
      ctr_nxt  = 2'b11;
    end else if (!up_hit) begin
      if (upd_taken) begin
        wr_alloc = 1'b1;
        wr_tgt   = 1'b1;
        wr_ctr   = 1'b1;
        ctr_nxt  = 2'b10;
      end
    end else if (upd_taken) begin
      wr_tgt = 1'b1;
      wr_ctr = 1'b1;
      case (MODE)
        1:       ctr_nxt = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01;
        2:       ctr_nxt = (cur_ctr == 2'b00) ? 2'b01 : 2'b11;
        default: ctr_nxt = cur_ctr;
      endcase
    end else begin
      // Always-taken mode has no counter to weaken, so a not-taken hit evicts the entry
      case (MODE)
        0:       inval   = 1'b1;
        1:       ctr_nxt = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01;
        2:       ctr_nxt = (cur_ctr == 2'b11) ? 2'b10 : 2'b00;
        default: ctr_nxt = cur_ctr;
      endcase
      wr_ctr = (MODE != 0);
    end
  end

  // Arrays other than valid are not reset; stale contents are masked by valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (wr_alloc) begin
        valid_q[up_idx] <= 1'b1;
        tag_mem[up_idx] <= up_tag;
      end
      if (inval)  valid_q[up_idx] <= 1'b0;
      if (wr_tgt) tgt_mem[up_idx] <= upd_target;
      if (wr_ctr) ctr_mem[up_idx] <= ctr_nxt;
    end
  end

  logic [WORD_SIZE-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]     ras_cnt;
  logic                 ras_nonempty, ras_full;

  assign ptr_inc      = ras_ptr + 1'b1;
  assign ptr_dec      = ras_ptr - 1'b1;
  assign ras_nonempty = (ras_cnt != '0);
  assign ras_full     = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_empty    = ~ras_nonempty;
  assign ras_top      = ras_nonempty ? ras_mem[ras_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push && ras_pop && ras_nonempty) begin
      ras_mem[ras_ptr] <= ras_push_addr;
    end else if (ras_push) begin
      // Wraps onto the oldest entry when full; count just stays saturated
      ras_mem[ptr_inc] <= ras_push_addr;
      ras_ptr          <= ptr_inc;
      if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop && ras_nonempty) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 1'b1;
      if (upd_mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Scoreboard bench: three predictor instances (modes 1, 2 and 0) share one stimulus stream;
// expected values are queued per step and compared by a negedge monitor.
module tb_branch_predictor_pht;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        upd_valid, upd_taken, upd_is_jump, upd_mispredict, clear;
  logic [15:0] upd_pc, upd_target;
  logic        ras_push, ras_pop;
  logic [15:0] ras_push_addr;

  logic        a_pt, b_pt, z_pt;
  logic [15:0] a_tgt, b_tgt, z_tgt;
  logic [15:0] a_top, b_top, z_top;
  logic        a_empty, b_empty, z_empty;
  logic [15:0] a_stu, a_stm, z_stu, z_stm;
  logic [1:0]  b_stu, b_stm;

  always #5 clk = ~clk;

  branch_predictor_pht #(.MODE(1), .STAT_W(16)) u_a (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predict_taken(a_pt), .predict_target(a_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_mispredict(upd_mispredict), .clear(clear),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_top(a_top), .ras_empty(a_empty), .stat_updates(a_stu), .stat_mispredicts(a_stm));

  branch_predictor_pht #(.MODE(2), .STAT_W(2)) u_b (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predict_taken(b_pt), .predict_target(b_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_mispredict(upd_mispredict), .clear(clear),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_top(b_top), .ras_empty(b_empty), .stat_updates(b_stu), .stat_mispredicts(b_stm));

  branch_predictor_pht #(.MODE(0), .STAT_W(16)) u_z (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predict_taken(z_pt), .predict_target(z_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_mispredict(upd_mispredict), .clear(clear),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .ras_top(z_top), .ras_empty(z_empty), .stat_updates(z_stu), .stat_mispredicts(z_stm));

  localparam int A_PT = 0, A_TGT = 1, B_PT = 2, Z_PT = 3, A_TOP = 4, A_EMPTY = 5;
  localparam int A_STU = 6, A_STM = 7, B_STU = 8, B_STM = 9;

  typedef struct {
    int          sel;
    logic [15:0] val;
    string       name;
    int          step;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic logic [15:0] act(input int sel);
    case (sel)
      A_PT:    return {15'b0, a_pt};
      A_TGT:   return a_tgt;
      B_PT:    return {15'b0, b_pt};
      Z_PT:    return {15'b0, z_pt};
      A_TOP:   return a_top;
      A_EMPTY: return {15'b0, a_empty};
      A_STU:   return a_stu;
      A_STM:   return a_stm;
      B_STU:   return {14'b0, b_stu};
      B_STM:   return {14'b0, b_stm};
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act(e.sel) !== e.val) begin
        errors++;
        $display("FAIL %s step=%0d actual=%h expected=%h", e.name, e.step, act(e.sel), e.val);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired: stimulus did not complete, checks=%0d", checks);
    $finish;
  end

  task automatic check_now(input int sel, input logic [15:0] v, input string n);
    checks++;
    if (act(sel) !== v) begin
      errors++;
      $display("FAIL %s (immediate) step=%0d actual=%h expected=%h", n, step_no, act(sel), v);
    end
  endtask

  task automatic expect_v(input int sel, input logic [15:0] v, input string n);
    exp_t e;
    e.sel = sel; e.val = v; e.name = n; e.step = step_no;
    sb_q.push_back(e);
  endtask

  task automatic pts(input logic pa, input logic pb, input logic pz);
    expect_v(A_PT, {15'b0, pa}, "a_predict_taken");
    expect_v(B_PT, {15'b0, pb}, "b_predict_taken");
    expect_v(Z_PT, {15'b0, pz}, "z_predict_taken");
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk,
                     input logic jmp, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
    upd_taken = tk; upd_is_jump = jmp; upd_mispredict = mis;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_no++;
    upd_valid = 1'b0; upd_is_jump = 1'b0; upd_mispredict = 1'b0; upd_taken = 1'b0;
    clear = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
  endtask

  task automatic push(input logic [15:0] a);
    ras_push = 1'b1; ras_push_addr = a;
  endtask

  initial begin
    reset = 1'b1; lookup_pc = 16'h0010;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_is_jump = 0; upd_mispredict = 0;
    clear = 0; ras_push = 0; ras_pop = 0; ras_push_addr = 0;
    @(posedge clk); #1;
    check_now(A_PT, 16'd0, "reset_now_a_predict_taken");
    check_now(A_EMPTY, 16'd1, "reset_now_ras_empty");
    check_now(A_TOP, 16'h0000, "reset_now_ras_top");
    check_now(A_STU, 16'd0, "reset_now_stat_updates");
    pts(0, 0, 0);
    expect_v(A_EMPTY, 16'd1, "reset_ras_empty");
    expect_v(A_TOP, 16'h0000, "reset_ras_top");
    expect_v(A_STU, 16'd0, "reset_stat_updates");
    expect_v(A_STM, 16'd0, "reset_stat_mispredicts");
    expect_v(B_STU, 16'd0, "reset_b_stat_updates");
    tick();
    reset = 1'b0;

    // Direction counters: each step checks the state left by the previous update
    upd(16'h0010, 16'h0020, 1, 0, 0); pts(0, 0, 0); expect_v(A_STU, 16'd0, "stu_before_first"); tick();
    upd(16'h0010, 16'h0000, 0, 0, 1); pts(1, 1, 1); expect_v(A_TGT, 16'h0020, "alloc_target");
    expect_v(A_STU, 16'd1, "stu_after_first"); tick();
    upd(16'h0010, 16'h0000, 0, 0, 0); pts(0, 0, 0); expect_v(A_STM, 16'd1, "stm_one"); tick();
    upd(16'h0010, 16'h0020, 1, 0, 1); pts(0, 0, 0); tick();
    upd(16'h0010, 16'h0020, 1, 0, 1); pts(0, 0, 1); tick();
    upd(16'h0010, 16'h0000, 0, 0, 1); pts(1, 1, 1);
    expect_v(A_STU, 16'd5, "stu_five"); expect_v(A_STM, 16'd3, "stm_three");
    expect_v(B_STU, 16'd3, "b_stu_saturated"); expect_v(B_STM, 16'd3, "b_stm_three"); tick();
    upd(16'h0010, 16'h0000, 0, 0, 0); pts(0, 1, 0); tick();
    upd(16'h0010, 16'h0020, 1, 0, 0); pts(0, 0, 0); tick();

    // Aliasing, jump install, clear priority
    upd(16'h0110, 16'h0111, 1, 0, 0); pts(0, 0, 1); tick();
    lookup_pc = 16'h0110;
    upd(16'h0210, 16'h0222, 1, 0, 0); pts(1, 1, 1); expect_v(A_TGT, 16'h0111, "alias_first_target"); tick();
    upd(16'h0210, 16'h0300, 1, 1, 0); pts(0, 0, 0); tick();
    lookup_pc = 16'h0210;
    upd(16'h0210, 16'h0000, 0, 0, 0); pts(1, 1, 1); expect_v(A_TGT, 16'h0300, "jump_target"); tick();
    clear = 1'b1;
    upd(16'h0210, 16'h0400, 1, 1, 1); pts(1, 1, 0); expect_v(A_TGT, 16'h0300, "pre_clear_target");
    expect_v(A_STU, 16'd12, "stu_pre_clear"); expect_v(A_STM, 16'd4, "stm_pre_clear"); tick();
    pts(0, 0, 0); expect_v(A_STU, 16'd12, "stu_after_clear"); expect_v(A_STM, 16'd4, "stm_after_clear"); tick();
    lookup_pc = 16'h0010;
    pts(0, 0, 0); tick();

    // Return-address stack
    push(16'h00A1); expect_v(A_EMPTY, 16'd1, "ras_empty_start"); tick();
    push(16'h00A2); expect_v(A_TOP, 16'h00A1, "ras_push1"); tick();
    push(16'h00A3); expect_v(A_TOP, 16'h00A2, "ras_push2"); tick();
    push(16'h00A4); expect_v(A_TOP, 16'h00A3, "ras_push3"); tick();
    push(16'h00A5); expect_v(A_TOP, 16'h00A4, "ras_push4"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00A5, "ras_overflow_top"); expect_v(A_EMPTY, 16'd0, "ras_nonempty"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00A4, "ras_pop1"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00A3, "ras_pop2"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00A2, "ras_pop3"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h0000, "ras_drained_top"); expect_v(A_EMPTY, 16'd1, "ras_drained_empty"); tick();
    expect_v(A_TOP, 16'h0000, "ras_pop_empty_top"); expect_v(A_EMPTY, 16'd1, "ras_pop_empty_flag"); tick();
    push(16'h00D0); ras_pop = 1'b1; tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00D0, "ras_pushpop_empty"); expect_v(A_EMPTY, 16'd0, "ras_pushpop_empty_flag"); tick();
    expect_v(A_EMPTY, 16'd1, "ras_empty_again"); tick();
    push(16'h00C1); tick();
    push(16'h00C2); expect_v(A_TOP, 16'h00C1, "ras_c1"); tick();
    push(16'h00B0); ras_pop = 1'b1; expect_v(A_TOP, 16'h00C2, "ras_c2"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00B0, "ras_replace_top"); expect_v(A_EMPTY, 16'd0, "ras_replace_nonempty"); tick();
    ras_pop = 1'b1; expect_v(A_TOP, 16'h00C1, "ras_count_kept"); tick();
    expect_v(A_EMPTY, 16'd1, "ras_final_empty"); expect_v(A_TOP, 16'h0000, "ras_final_top"); tick();

    // Statistics saturation and asynchronous reset
    reset = 1'b1;
    expect_v(A_STU, 16'd0, "async_reset_stu"); expect_v(B_STU, 16'd0, "async_reset_b_stu");
    expect_v(B_STM, 16'd0, "async_reset_b_stm"); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      upd(16'h0030, 16'h0040, 1, 0, 1); tick();
    end
    lookup_pc = 16'h0030;
    pts(1, 1, 1); expect_v(A_TGT, 16'h0040, "stat_phase_target");
    expect_v(A_STU, 16'd5, "stat_a_stu"); expect_v(A_STM, 16'd5, "stat_a_stm");
    expect_v(B_STU, 16'd3, "stat_b_stu_sat"); expect_v(B_STM, 16'd3, "stat_b_stm_sat"); tick();
    upd(16'h0030, 16'h0050, 1, 1, 1); reset = 1'b1;
    pts(0, 0, 0); expect_v(A_STU, 16'd0, "midstream_a_stu");
    expect_v(B_STU, 16'd0, "midstream_b_stu"); expect_v(B_STM, 16'd0, "midstream_b_stm"); tick();
    reset = 1'b0;
    pts(0, 0, 0); expect_v(A_STU, 16'd0, "aborted_update_stu"); tick();

    @(negedge clk); #1;
    if (errors != 0) $display("FAIL CHECKS %0d ERRORS %0d", checks, errors);
    else             $display("PASS CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
